// File: rtl/rv_pipe_pkg.sv
// Shared types for the RV32I pipeline hazard logic.
// REG_ADDR_W   : width of a register address (x0..x31)
// reg_addr_t   : register address type
// sb_entry_t   : one scoreboard slot {valid, rd}
// SB_EX/MEM/WB : slot index of each stage in the scoreboard array
package rv_pipe_pkg;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef struct packed {
    logic      valid;
    reg_addr_t rd;
  } sb_entry_t;

  localparam int SB_EX  = 0;
  localparam int SB_MEM = 1;
  localparam int SB_WB  = 2;
endpackage

// File: rtl/rv_sb_match.sv
// Compares one source register of the ID instruction against the three
// in-flight destination slots and flags a RAW hazard.
// i_rs     : source register address
// i_use    : ID instruction actually reads i_rs
// i_sb     : scoreboard slots, indexed by SB_EX/SB_MEM/SB_WB
// o_hazard : source depends on an unfinished write
module rv_sb_match
  import rv_pipe_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1
) (
  input  reg_addr_t       i_rs,
  input  logic            i_use,
  input  sb_entry_t [2:0] i_sb,
  output logic            o_hazard
);

  logic [2:0] w_match;

  // x0 is hardwired zero, so it can never depend on a writer.
  for (genvar s = 0; s < 3; s++) begin : g_cmp
    assign w_match[s] = i_sb[s].valid && (i_sb[s].rd == i_rs) && (i_rs != '0);
  end

  // With bypass the register file writes in the first half-cycle, so a
  // writer sitting in WB is already visible to the ID read.
  assign o_hazard = i_use && (w_match[SB_EX] || w_match[SB_MEM] ||
                              (!WB_BYPASS && w_match[SB_WB]));

endmodule

// File: rtl/rv_hazard_scoreboard.sv
// RAW hazard scoreboard for the 5-stage RV32I core. Tracks destination
// registers of writes in EX/MEM/WB, stalls ID on a dependency, drives the
// register file write port from the WB slot and counts stall cycles.
// clk, reset        : clock, synchronous active-high reset
// i_id_*            : instruction currently in ID
// i_flush           : taken branch/jump in EX kills the ID instruction
// o_stall           : hold PC and IF/ID, bubble into EX
// o_wb_rd / o_wb_we : register file write address / enable
// o_stall_cnt       : saturating stall-cycle counter
module rv_hazard_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter bit WB_BYPASS = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_id_valid,
  input  reg_addr_t        i_id_rs1,
  input  reg_addr_t        i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  input  reg_addr_t        i_id_rd,
  input  logic             i_id_reg_write,
  input  logic             i_flush,
  output logic             o_stall,
  output reg_addr_t        o_wb_rd,
  output logic             o_wb_we,
  output logic [CNT_W-1:0] o_stall_cnt
);

  sb_entry_t [2:0]  r_sb;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_haz_rs1;
  logic             w_haz_rs2;
  sb_entry_t        w_ex_in;

  rv_sb_match #(.WB_BYPASS(WB_BYPASS)) u_match_rs1 (
    .i_rs     (i_id_rs1),
    .i_use    (i_id_use_rs1),
    .i_sb     (r_sb),
    .o_hazard (w_haz_rs1)
  );

  rv_sb_match #(.WB_BYPASS(WB_BYPASS)) u_match_rs2 (
    .i_rs     (i_id_rs2),
    .i_use    (i_id_use_rs2),
    .i_sb     (r_sb),
    .o_hazard (w_haz_rs2)
  );

  // Flush wins over stall: a killed instruction never holds the pipe.
  assign o_stall = !reset && i_id_valid && !i_flush && (w_haz_rs1 || w_haz_rs2);

  // Entry entering EX: bubble unless a live instruction is accepted;
  // rd=0 writes are recorded as invalid so x0 is never tracked.
  always_comb begin
    w_ex_in = '0;
    if (i_id_valid && !o_stall && !i_flush) begin
      w_ex_in.valid = i_id_reg_write && (i_id_rd != '0);
      w_ex_in.rd    = i_id_rd;
    end
  end

  // EX->MEM->WB advances every cycle; only the EX input is gated.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sb <= '0;
    end else begin
      r_sb[SB_EX]  <= w_ex_in;
      r_sb[SB_MEM] <= r_sb[SB_EX];
      r_sb[SB_WB]  <= r_sb[SB_MEM];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (o_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_wb_we     = r_sb[SB_WB].valid;
  assign o_wb_rd     = r_sb[SB_WB].rd;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: doc/rv_hazard_scoreboard.md
Name: rv_hazard_scoreboard

Overview:
- Consumer of the in-flight destination-register stream for the 5-stage RV32I core (ID→EX→MEM→WB).
- Tracks destination register addresses of in-flight writes across EX, MEM and WB in a 3-deep {valid, rd} pipeline.
- Detects RAW hazards for the instruction in ID and issues a stall that freezes IF/ID and inserts a bubble into EX.
- Supplies the WB-stage write address and enable to the register file, and counts stall cycles for performance analysis.

Parameters:
- REG_ADDR_W, 5, width of a register address (x0..x31).
- WB_BYPASS, 1, 1 = register file writes before it reads, so a WB-stage match is not a hazard. 0 = a WB match stalls.
- CNT_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs1  in  REG_ADDR_W  source register 1 of the ID instruction.
- id_rs2  in  REG_ADDR_W  source register 2 of the ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_ADDR_W  destination register of the ID instruction.
- id_reg_write  in  1  ID instruction writes rd.
- flush  in  1  branch/jump taken in EX; kill the ID instruction.
- stall  out  1  hold PC and IF/ID; EX receives a bubble.
- wb_rd  out  REG_ADDR_W  register file write address.
- wb_we  out  1  register file write enable.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Clock and reset: clk, rising edge. reset is synchronous, active-high.
- Reset: all three entries become valid=0, rd=0. stall_cnt=0, wb_we=0, wb_rd=0. stall is forced to 0 while reset=1.
- Entry written into EX each cycle:
  - If reset: cleared.
  - Else if stall or flush or !id_valid: bubble (valid=0, rd=0).
  - Else: valid = id_reg_write && (id_rd != 0), rd = id_rd.
  - EX→MEM→WB shift unconditionally every non-reset cycle. The 3-cycle latency from ID acceptance to WB is fixed.
- Matching: match_X(r) = entry_X.valid && entry_X.rd == r && r != 0.
- Source hazard for rs1: id_use_rs1 && (match_EX(rs1) || match_MEM(rs1) || (!WB_BYPASS && match_WB(rs1))). The rs2 hazard is the same with id_use_rs2 and rs2.
- stall = !reset && id_valid && !flush && (hazard_rs1 || hazard_rs2). This is combinational from the ID inputs and registered entries.
- flush has priority over stall: the killed instruction never stalls and never enters the scoreboard.
- wb_we = WB.valid and wb_rd = WB.rd, both driven directly from registers.
- x0 is never tracked and never causes a hazard: rd=0 is inserted as invalid.
- Stall duration: worst case (producer directly ahead) with WB_BYPASS=1 is 2 cycles; with WB_BYPASS=0 it is 3 cycles.
- stall_cnt increments on every cycle with stall=1 and saturates at 2^CNT_W-1 with no wrap.
- Reset mid-stall: stall drops in the same cycle reset is sampled high. All entries are cleared on that edge.
- Simultaneous rs1 and rs2 hazards on different stages: the stall lasts until both clear, i.e. the longer of the two.

Decomposition:
- Package rv_pipe_pkg contains:
  - REG_ADDR_W.
  - typedef reg_addr_t = logic [REG_ADDR_W-1:0].
  - typedef struct packed {logic valid; reg_addr_t rd;} sb_entry_t.
  - Stage index constants SB_EX=0, SB_MEM=1, SB_WB=2.
- Sub-module rv_sb_match: combinational compare of one source address against three entries. It takes a WB_BYPASS parameter and is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Reset check: assert reset for 2 cycles with id_valid=1, rd=5, reg_write=1. Required: stall=0, wb_we=0, stall_cnt=0 throughout. After release, wb_we=1 with wb_rd=5 exactly 3 cycles after the first accepted instruction.
- Back-to-back RAW, WB_BYPASS=1: issue "add x3" then "add x4,x3,x1". Required: stall=1 for 2 cycles, 2 bubbles enter EX, stall_cnt=2, then x4 is accepted. With WB_BYPASS=0: 3 stall cycles, stall_cnt=3.
- x0 and unused source: issue rd=0 writer, then a reader of x0 with use_rs2=0 and rs2 matching an in-flight rd. Required: no stall, wb_we stays 0 for the x0 writer.
- Flush priority: a hazardous instruction in ID with flush=1 in the same cycle. Required: stall=0, a bubble enters EX, and no wb_we for that instruction 3 cycles later.
- Dual hazard: x5 in MEM and x6 in EX, then an ID instruction reads rs1=x5, rs2=x6. Required: stall for 2 cycles (until x6 leaves MEM); x5 alone would have cleared after 1 cycle.
- Saturation and mid-stall reset: with CNT_W=4, force 20 stall cycles. Required: stall_cnt holds at 15. Then assert reset during a stall. Required: stall=0 in that cycle, all entries and stall_cnt are 0 on the following cycle.
